cube_edge_seq: RTL and testbench

CUBE_EDGE_SEQ -- requirements
Module: cube_edge_seq

---
 rtl/cube_edge_seq.sv | 170 +++++++++++++++++
 tb/tb_cube_edge_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_edge_seq.sv
// Sequences the 12 edges of an oblique-projection cube into a single-line drawer.
// Define CUBE_HIDDEN_EDGE_SKIP_EN to skip the three edges touching hidden vertex V7.
module cube_edge_seq #(
    parameter int XW = 11,
    parameter int YW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [XW-1:0] x_offset,
    input  logic [YW-1:0] y_offset,
    input  logic [YW-1:0] size,
    input  logic [YW-1:0] depth,
    output logic [XW-1:0] x0,
    output logic [XW-1:0] x1,
    output logic [YW-1:0] y0,
    output logic [YW-1:0] y1,
    output logic          line_start,
    input  logic          line_done,
    output logic [3:0]    edge_idx,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        NEXT,
        DONE
    } state_t;

    state_t        r_state;
    logic [XW-1:0] r_vx [8];
    logic [YW-1:0] r_vy [8];

    logic [XW:0]   w_xRightSum;
    logic [XW:0]   w_xLeftBackSum;
    logic [XW:0]   w_xRightBackSum;
    logic [YW:0]   w_yBottomSum;
    logic [XW-1:0] w_xRight;
    logic [XW-1:0] w_xLeftBack;
    logic [XW-1:0] w_xRightBack;
    logic [YW-1:0] w_yBottom;
    logic [YW-1:0] w_yTopBack;
    logic [YW-1:0] w_yBottomBack;

    logic [3:0]    w_nextIdx;
    logic          w_lastEdge;
    logic [3:0]    w_issueIdx;
    logic [2:0]    w_vertA;
    logic [2:0]    w_vertB;

    // First endpoint: front edges start at V(idx), back edges at V(idx), depth edges at V(idx-8)
    function automatic logic [2:0] edgeA(input logic [3:0] idx);
        if (idx < 4'd8) edgeA = idx[2:0];
        else            edgeA = {1'b0, idx[1:0]};
    endfunction

    function automatic logic [2:0] edgeB(input logic [3:0] idx);
        if (idx < 4'd4)      edgeB = {1'b0, idx[1:0] + 2'd1};
        else if (idx < 4'd8) edgeB = {1'b1, idx[1:0] + 2'd1};
        else                 edgeB = {1'b1, idx[1:0]};
    endfunction

    // Sums carry one extra bit so overflow saturates; back-face y clamps at zero
    always_comb begin
        w_xRightSum     = {1'b0, x_offset} + (XW+1)'(size);
        w_xRight        = w_xRightSum[XW] ? '1 : w_xRightSum[XW-1:0];
        w_xLeftBackSum  = {1'b0, x_offset} + (XW+1)'(depth);
        w_xLeftBack     = w_xLeftBackSum[XW] ? '1 : w_xLeftBackSum[XW-1:0];
        w_xRightBackSum = {1'b0, w_xRight} + (XW+1)'(depth);
        w_xRightBack    = w_xRightBackSum[XW] ? '1 : w_xRightBackSum[XW-1:0];
        w_yBottomSum    = {1'b0, y_offset} + {1'b0, size};
        w_yBottom       = w_yBottomSum[YW] ? '1 : w_yBottomSum[YW-1:0];
        w_yTopBack      = (depth > y_offset) ? '0 : y_offset - depth;
        w_yBottomBack   = (depth > w_yBottom) ? '0 : w_yBottom - depth;
    end

    always_comb begin
        w_nextIdx  = edge_idx + 4'd1;
        w_lastEdge = (edge_idx == 4'd11);
`ifdef CUBE_HIDDEN_EDGE_SKIP_EN
        if (edge_idx == 4'd5) w_nextIdx = 4'd8;
        w_lastEdge = (edge_idx == 4'd10);
`endif
        w_issueIdx = (r_state == LOAD) ? 4'd0 : w_nextIdx;
        w_vertA    = edgeA(w_issueIdx);
        w_vertB    = edgeB(w_issueIdx);
    end

    // Single control FSM; every output is a register updated on entry to the state that shows it
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            line_start <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            edge_idx   <= 4'd0;
            x0         <= '0;
            x1         <= '0;
            y0         <= '0;
            y1         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_vx[0]  <= x_offset;
                        r_vx[1]  <= w_xRight;
                        r_vx[2]  <= w_xRight;
                        r_vx[3]  <= x_offset;
                        r_vx[4]  <= w_xLeftBack;
                        r_vx[5]  <= w_xRightBack;
                        r_vx[6]  <= w_xRightBack;
                        r_vx[7]  <= w_xLeftBack;
                        r_vy[0]  <= y_offset;
                        r_vy[1]  <= y_offset;
                        r_vy[2]  <= w_yBottom;
                        r_vy[3]  <= w_yBottom;
                        r_vy[4]  <= w_yTopBack;
                        r_vy[5]  <= w_yTopBack;
                        r_vy[6]  <= w_yBottomBack;
                        r_vy[7]  <= w_yBottomBack;
                        edge_idx <= 4'd0;
                        busy     <= 1'b1;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    edge_idx   <= 4'd0;
                    x0         <= r_vx[w_vertA];
                    y0         <= r_vy[w_vertA];
                    x1         <= r_vx[w_vertB];
                    y1         <= r_vy[w_vertB];
                    line_start <= 1'b1;
                    r_state    <= ISSUE;
                end
                ISSUE: begin
                    line_start <= 1'b0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (line_done) r_state <= NEXT;
                end
                NEXT: begin
                    if (w_lastEdge) begin
                        frame_done <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        edge_idx   <= w_nextIdx;
                        x0         <= r_vx[w_vertA];
                        y0         <= r_vy[w_vertA];
                        x1         <= r_vx[w_vertB];
                        y1         <= r_vy[w_vertB];
                        line_start <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cube_edge_seq.sv
// Scoreboard bench for cube_edge_seq: a geometric cube model fills an edge queue,
// a drawer model answers each line_start, and a monitor checks every issued edge.
module tb_cube_edge_seq;

    localparam int XW   = 11;
    localparam int YW   = 10;
    localparam int XMAX = (1 << XW) - 1;
    localparam int YMAX = (1 << YW) - 1;
`ifdef CUBE_HIDDEN_EDGE_SKIP_EN
    localparam int NEDGES = 9;
`else
    localparam int NEDGES = 12;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic [XW-1:0] xOffset = '0;
    logic [YW-1:0] yOffset = '0;
    logic [YW-1:0] size = '0;
    logic [YW-1:0] depth = '0;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic          lineStart;
    logic          drawerDone = 1'b0;
    logic          extraDone = 1'b0;
    logic          lineDone;
    logic [3:0]    edgeIdx;
    logic          busy;
    logic          frameDone;

    assign lineDone = drawerDone | extraDone;

    cube_edge_seq #(.XW(XW), .YW(YW)) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .x_offset   (xOffset),
        .y_offset   (yOffset),
        .size       (size),
        .depth      (depth),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .line_start (lineStart),
        .line_done  (lineDone),
        .edge_idx   (edgeIdx),
        .busy       (busy),
        .frame_done (frameDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int ax;
        int ay;
        int bx;
        int by;
    } edge_t;

    edge_t expQ[$];
    int    checkCount = 0;
    int    passCount = 0;
    int    startsThisFrame = 0;
    int    frameCount = 0;
    int    expFrames = 0;
    int    unstable = 0;
    int    drawerDelay = 5;
    bit    spurious = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic int minI(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int maxI(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Cube geometry: front square plus a back square shifted right by d and up by d
    function automatic void buildExpected(input int xo, input int yo, input int s, input int d);
        int    vx[8];
        int    vy[8];
        int    ea[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
        int    eb[12] = '{1, 2, 3, 0, 5, 6, 7, 4, 4, 5, 6, 7};
        edge_t item;
        vx[0] = xo;                 vy[0] = yo;
        vx[1] = minI(xo + s, XMAX); vy[1] = yo;
        vx[2] = minI(xo + s, XMAX); vy[2] = minI(yo + s, YMAX);
        vx[3] = xo;                 vy[3] = minI(yo + s, YMAX);
        for (int i = 4; i < 8; i++) begin
            vx[i] = minI(vx[i-4] + d, XMAX);
            vy[i] = maxI(vy[i-4] - d, 0);
        end
        for (int e = 0; e < 12; e++) begin
`ifdef CUBE_HIDDEN_EDGE_SKIP_EN
            if (ea[e] == 7 || eb[e] == 7) continue;
`endif
            item.idx = e;
            item.ax  = vx[ea[e]];
            item.ay  = vy[ea[e]];
            item.bx  = vx[eb[e]];
            item.by  = vy[eb[e]];
            expQ.push_back(item);
        end
    endfunction

    // Line-drawer model: holds off for a delay, checks endpoints stay put, then answers
    always begin
        int delayCycles;
        int cx0, cy0, cx1, cy1;
        @(negedge clk);
        if (reset && lineStart) begin
            cx0 = x0; cy0 = y0; cx1 = x1; cy1 = y1;
            delayCycles = (drawerDelay > 0) ? drawerDelay : $urandom_range(1, 6);
            drawerDone = spurious;
            for (int k = 0; k < delayCycles; k++) begin
                @(negedge clk);
                drawerDone = 1'b0;
                if (reset && busy && (x0 != cx0 || y0 != cy0 || x1 != cx1 || y1 != cy1))
                    unstable++;
            end
            drawerDone = 1'b1;
            @(negedge clk);
            drawerDone = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on each line_start and audits each frame_done
    always @(negedge clk) begin
        edge_t e;
        if (reset) begin
            if (lineStart) begin
                startsThisFrame++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedStart", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("edgeIdx", int'(edgeIdx), e.idx);
                    checkOutput("x0", int'(x0), e.ax);
                    checkOutput("y0", int'(y0), e.ay);
                    checkOutput("x1", int'(x1), e.bx);
                    checkOutput("y1", int'(y1), e.by);
                end
            end
            if (frameDone) begin
                frameCount++;
                checkOutput("startsPerFrame", startsThisFrame, NEDGES);
                checkOutput("edgesRemaining", expQ.size(), 0);
                checkOutput("endpointsStable", unstable, 0);
                startsThisFrame = 0;
                unstable = 0;
            end
        end
    end

    task automatic checkResetOutputs();
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstLineStart", int'(lineStart), 0);
        checkOutput("rstFrameDone", int'(frameDone), 0);
        checkOutput("rstEdgeIdx", int'(edgeIdx), 0);
        checkOutput("rstX0", int'(x0), 0);
        checkOutput("rstX1", int'(x1), 0);
        checkOutput("rstY0", int'(y0), 0);
        checkOutput("rstY1", int'(y1), 0);
    endtask

    // Issues one go pulse (called at a negedge) and checks the start latency
    task automatic applyStimulus(input int xo, input int yo, input int s, input int d);
        buildExpected(xo, yo, s, d);
        expFrames++;
        checkOutput("busyIdle", int'(busy), 0);
        xOffset = XW'(xo);
        yOffset = YW'(yo);
        size    = YW'(s);
        depth   = YW'(d);
        go      = 1'b1;
        @(negedge clk);
        go      = 1'b0;
        xOffset = XW'($urandom);
        yOffset = YW'($urandom);
        size    = YW'($urandom);
        depth   = YW'($urandom);
        checkOutput("busyLoad", int'(busy), 1);
        checkOutput("startEarly", int'(lineStart), 0);
        @(negedge clk);
        checkOutput("startLatency", int'(lineStart), 1);
    endtask

    task automatic waitFrame();
        int target;
        bit seen;
        target = expFrames;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (frameCount >= target) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput("frameTimeout", 0, 1);
        end else begin
            @(negedge clk);
            checkOutput("busyAfterFrame", int'(busy), 0);
        end
    endtask

    task automatic waitEdgeWait(input int idx);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (busy && !lineStart && int'(edgeIdx) == idx) found = 1'b1;
        end
        if (!found) checkOutput("edgeWaitTimeout", 0, 1);
    endtask

    initial begin
        go = 1'b1;
        repeat (3) @(negedge clk);
        go = 1'b0;
        checkResetOutputs();
        reset = 1'b1;
        repeat (10) @(negedge clk);

        extraDone = 1'b1;
        @(negedge clk);
        extraDone = 1'b0;
        repeat (5) @(negedge clk);

        drawerDelay = 5;
        applyStimulus(50, 100, 40, 20);
        waitFrame();
        applyStimulus(2040, 5, 40, 20);
        waitFrame();
        applyStimulus(300, 200, 0, 0);
        waitFrame();

        spurious = 1'b1;
        drawerDelay = 0;
        applyStimulus(50, 100, 40, 20);
        waitEdgeWait(3);
        xOffset = 11'd7;
        size    = 10'd3;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        waitFrame();
        spurious = 1'b0;
        repeat (10) @(negedge clk);

        applyStimulus(100, 100, 30, 10);
        waitEdgeWait(5);
        reset = 1'b0;
        @(negedge clk);
        checkResetOutputs();
        expQ.delete();
        expFrames--;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        startsThisFrame = 0;
        unstable = 0;
        applyStimulus(120, 60, 25, 15);
        waitFrame();

        for (int n = 0; n < 20; n++) begin
            spurious = 1'($urandom_range(0, 1));
            applyStimulus($urandom_range(0, XMAX), $urandom_range(0, 599),
                          $urandom_range(0, 399), $urandom_range(0, 399));
            waitFrame();
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        spurious = 1'b0;
        repeat (20) @(negedge clk);

        checkOutput("frameCount", frameCount, expFrames);
        checkOutput("queueDrained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
